// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 codes, FSM states and access-legality helper
// shared by the load/store unit and its lane aligner.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    // Illegal size encodings plus halfword/word alignment rules.
    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] off);
        logic illegal;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return illegal
            || (f3[1:0] == F3_LH[1:0] && off[0])
            || (f3[1:0] == F3_LW[1:0] && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: store lane replication / byte enables and load byte/half
// extraction with sign or zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;

    assign ld_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = ld_word_i[{ld_off_i[1], 4'b0000} +: 16];
    assign ld_sext = ~ld_funct3_i[2];

    always_comb begin
        st_be_o   = st_funct3_i[1:0] == F3_SB[1:0] ? 4'b0001 << st_off_i
                  : st_funct3_i[1:0] == F3_SH[1:0] ? (st_off_i[1] ? 4'b1100 : 4'b0011)
                  : 4'hF;
        st_data_o = st_funct3_i[1:0] == F3_SB[1:0] ? {4{st_data_i[7:0]}}
                  : st_funct3_i[1:0] == F3_SH[1:0] ? {2{st_data_i[15:0]}}
                  : st_data_i;
        ld_data_o = ld_funct3_i[1:0] == F3_LB[1:0] ? {{24{ld_sext & ld_byte[7]}}, ld_byte}
                  : ld_funct3_i[1:0] == F3_LH[1:0] ? {{16{ld_sext & ld_half[15]}}, ld_half}
                  : ld_word_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: classifies loads/stores, runs the req/gnt/rvalid bus
// handshake with a timeout, and stalls the pipeline while the bus is busy.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        access_err,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        tmo_q, tmo_d;
    logic        access;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    assign access     = mem_read | mem_write;
    assign access_err = access & access_bad(funct3, addr[1:0]);
    assign stall      = (state_q == S_IDLE & access & ~access_err)
                      | state_q == S_REQ | state_q == S_WAIT;

    lsu_align u_align (
        .st_funct3_i (funct3),
        .st_off_i    (addr[1:0]),
        .st_data_i   (wdata),
        .st_be_o     (st_be),
        .st_data_o   (st_data),
        .ld_funct3_i (f3_q),
        .ld_off_i    (off_q),
        .ld_word_i   (bus_rdata),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !access_err) begin
                    state_d = S_REQ;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = mem_write ? st_be : 4'hF;
                    wdata_d = st_data;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A completion in the final counted cycle beats the timeout.
                if (state_q == S_REQ && bus_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? S_DONE : bus_rvalid ? S_DONE : S_WAIT;
                    rdata_d = !we_q && bus_rvalid ? ld_data : rdata_q;
                end else if (state_q == S_WAIT && bus_rvalid) begin
                    rdata_d = ld_data;
                    state_d = S_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = 32'd0;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rdata       = rdata_q;
    assign bus_timeout = tmo_q;
    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized loads/stores against a
// behavioural model of access legality, lane mapping, latency and timeout.
module tb_load_store_unit;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, access_err, bus_timeout, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_rd = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .stall       (stall),
        .access_err  (access_err),
        .bus_timeout (bus_timeout),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic illegal_acc(input logic [2:0] f3, input logic [31:0] a);
        int s = int'(f3);
        int lo = int'(a[1:0]);
        if (s == 3 || s == 6 || s == 7) return 1'b1;
        if ((s == 1 || s == 5) && lo % 2 != 0) return 1'b1;
        if (s == 2 && lo != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int s = int'(f3);
        if (s == 0 || s == 4) begin
            v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
            if (s == 0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 1 || s == 5) begin
            v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (s == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << int'(a[1:0]));
        if (f3 == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Enters and leaves on a falling edge; plays the bus slave with the given
    // grant latency (extra REQ cycles) and rvalid latency (cycles after grant).
    task automatic run_acc(input logic st, input logic rd, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                           input int glat, input int rlat);
        int stalls = 0, reqs = 0, waits = 0, exp_cyc, exp_req;
        logic granted = 1'b0, done = 1'b0, seen = 1'b0, tmo;
        logic [31:0] exp_rd;
        mem_write = st; mem_read = rd; funct3 = f3; addr = a; wdata = wd; bus_rdata = rw;
        #1;
        if (illegal_acc(f3, a)) begin
            chk("err_flag", 32'(access_err), 32'd1);
            chk("err_stall", 32'(stall), 32'd0);
            @(negedge clk);
            chk("err_req", 32'(bus_req), 32'd0);
            chk("err_rdata", rdata, model_rd);
            mem_write = 1'b0; mem_read = 1'b0;
            @(negedge clk);
            return;
        end
        chk("ok_flag", 32'(access_err), 32'd0);
        exp_cyc = st ? glat + 1 : glat + 1 + rlat;
        tmo = exp_cyc > T;
        if (tmo) exp_cyc = T;
        exp_req = glat + 1 > T ? T : glat + 1;
        exp_rd = tmo ? 32'd0 : st ? model_rd : ref_load(f3, a, rw);
        for (int c = 0; c < 200 && !done; c++) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (stall) begin
                stalls++;
                if (bus_req) begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                        chk("bus_we", 32'(bus_we), 32'(st));
                        chk("bus_be", 32'(bus_be), st ? 32'(ref_be(f3, a)) : 32'hF);
                        if (st) chk("bus_wdata", bus_wdata, ref_wdata(f3, wd));
                    end
                    reqs++;
                    if (reqs > glat) begin
                        bus_gnt = 1'b1; granted = 1'b1;
                        bus_rvalid = !st && rlat == 0;
                    end
                end else if (granted) begin
                    waits++;
                    bus_rvalid = waits >= rlat;
                end
            end else if (stalls > 0) begin
                done = 1'b1;
                chk("stall_cycles", stalls, exp_cyc + 1);
                chk("req_cycles", reqs, exp_req);
                chk("timeout", 32'(bus_timeout), 32'(tmo));
                chk("rdata", rdata, exp_rd);
                model_rd = exp_rd;
                mem_read = 1'b0; mem_write = 1'b0;
            end
            @(negedge clk);
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        chk("completed", 32'(done), 32'd1);
        chk("timeout_pulse", 32'(bus_timeout), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        logic       st;
        int         gl, rl;
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_tmo", 32'(bus_timeout), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_acc(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_acc(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lb_value", rdata, 32'hFFFF_FF80);
        run_acc(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
        chk("lbu_value", rdata, 32'h0000_0080);
        run_acc(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0);
        run_acc(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
        run_acc(1'b0, 1'b1, 3'b111, 32'h100, 32'h0, 32'h0, 0, 0);
        run_acc(1'b0, 1'b1, 3'b010, 32'h440, 32'h0, 32'h1111_2222, 0, 0);
        run_acc(1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 32'h5555_AAAA, 50, 0);
        run_acc(1'b0, 1'b1, 3'b001, 32'h502, 32'h0, 32'h9876_5432, 3, 4);
        run_acc(1'b1, 1'b1, 3'b000, 32'h601, 32'h0000_00A5, 32'h0, 7, 0);

        for (int i = 0; i < 80; i++) begin
            st = 1'($urandom_range(0, 1));
            if (st) begin
                gl = int'($urandom_range(0, 5));
                f3 = gl < 3 ? 3'(gl) : gl == 3 ? 3'b011 : gl == 4 ? 3'b110 : 3'b111;
            end else f3 = 3'($urandom_range(0, 7));
            gl = $urandom_range(0, 9) == 0 ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 2));
            rl = $urandom_range(0, 9) == 0 ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 2));
            run_acc(st, st ? 1'($urandom_range(0, 1)) : 1'b1, f3, $urandom, $urandom, $urandom, gl, rl);
        end

        if (rdata == 32'd0) run_acc(1'b0, 1'b1, 3'b010, 32'h700, 32'h0, 32'h0BAD_F00D, 0, 0);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mid_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("mid_wait_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_read = 1'b0; bus_rvalid = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("late_rvalid_rdata", rdata, 32'd0);
        chk("late_rvalid_req", 32'(bus_req), 32'd0);
        chk("late_rvalid_stall", 32'(stall), 32'd0);
        chk("late_rvalid_tmo", 32'(bus_timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
